// File: rtl/des_pkg.sv
// DES constant tables (1-based, DES bit order), key-rotation schedules, FSM encodings and permutation helpers.
// Shared by des_round_engine and des_round_function.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  // Decrypt walks the encrypt schedule backwards: C0/D0 already equals C16/D16.
  localparam int ENC_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int DEC_SHIFT [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [0:63] ip_perm(input logic [0:63] x);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) y[i] = x[IP_T[i]-1];
    return y;
  endfunction

  function automatic logic [0:63] fp_perm(input logic [0:63] x);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) y[i] = x[FP_T[i]-1];
    return y;
  endfunction

  function automatic logic [0:47] e_perm(input logic [0:31] x);
    logic [0:47] y;
    for (int i = 0; i < 48; i++) y[i] = x[E_T[i]-1];
    return y;
  endfunction

  function automatic logic [0:31] p_perm(input logic [0:31] x);
    logic [0:31] y;
    for (int i = 0; i < 32; i++) y[i] = x[P_T[i]-1];
    return y;
  endfunction

  function automatic logic [0:55] pc1_perm(input logic [0:63] x);
    logic [0:55] y;
    for (int i = 0; i < 56; i++) y[i] = x[PC1_T[i]-1];
    return y;
  endfunction

  function automatic logic [0:47] pc2_perm(input logic [0:55] x);
    logic [0:47] y;
    for (int i = 0; i < 48; i++) y[i] = x[PC2_T[i]-1];
    return y;
  endfunction

  function automatic logic [0:27] rot28(input logic [0:27] x, input logic dec, input int sh);
    if (!dec) return (sh == 1) ? {x[1:27], x[0]} : {x[2:27], x[0:1]};
    if (sh == 0) return x;
    return (sh == 1) ? {x[27], x[0:26]} : {x[26:27], x[0:25]};
  endfunction

endpackage

// File: rtl/des_round_function.sv
// DES f-function: E-expansion, round-key XOR, eight S-boxes and P permutation (purely combinational).
module des_sbox
  import des_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic [0:5] i_six,
  output logic [0:3] o_four
);
  // Outer bits pick the row, inner four the column.
  assign o_four = 4'(SBOX[IDX][{i_six[0], i_six[5], i_six[1:4]}]);
endmodule

module des_round_function
  import des_pkg::*;
(
  input  logic [0:31] i_r,
  input  logic [0:47] i_k,
  output logic [0:31] o_f
);
  logic [0:47] w_x;
  logic [0:31] w_s;

  assign w_x = e_perm(i_r) ^ i_k;

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    des_sbox #(.IDX(g)) u_sbox (
      .i_six  (w_x[6*g +: 6]),
      .o_four (w_s[4*g +: 4])
    );
  end

  assign o_f = p_perm(w_s);
endmodule

// File: rtl/des_round_engine.sv
// Iterative DES encrypt/decrypt: one Feistel round per clock, key schedule, IP/FP and handshake.
// Optional key_parity_err_dout output enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_round_engine
  import des_pkg::*;
#(
  parameter int ROUNDS = DES_ROUNDS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_strobe_din,
  input  logic        decrypt_din,
  input  logic [0:63] text_din,
  input  logic [0:63] key_din,
  output logic [0:63] text_dout,
  output logic        done_strobe_dout,
  output logic        busy_dout
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic [0:7]  key_parity_err_dout
`endif
);
  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

  logic [1:0]  r_state;
  logic [4:0]  r_round;
  logic        r_dec;
  logic [0:31] r_l, r_r;
  logic [0:27] r_c, r_d;
  logic [0:63] r_text;

  logic [0:63] w_ip;
  logic [0:55] w_cd0;
  int          w_sh;
  logic [0:27] w_c_rot, w_d_rot;
  logic [0:47] w_k;
  logic [0:31] w_f, w_r_nxt;
  logic        w_accept;

  assign w_accept = (r_state == S_IDLE) && start_strobe_din;
  assign w_ip     = ip_perm(text_din);
  assign w_cd0    = pc1_perm(key_din);

  assign w_sh    = r_dec ? DEC_SHIFT[r_round[3:0]] : ENC_SHIFT[r_round[3:0]];
  assign w_c_rot = rot28(r_c, r_dec, w_sh);
  assign w_d_rot = rot28(r_d, r_dec, w_sh);
  assign w_k     = pc2_perm({w_c_rot, w_d_rot});

  des_round_function u_f (
    .i_r (r_r),
    .i_k (w_k),
    .o_f (w_f)
  );

  assign w_r_nxt = r_l ^ w_f;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_round <= '0;
      r_dec   <= 1'b0;
      r_l     <= '0;
      r_r     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_text  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_l     <= w_ip[0:31];
          r_r     <= w_ip[32:63];
          r_c     <= w_cd0[0:27];
          r_d     <= w_cd0[28:55];
          r_dec   <= decrypt_din;
          r_round <= '0;
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_l <= r_r;
          r_r <= w_r_nxt;
          r_c <= w_c_rot;
          r_d <= w_d_rot;
          if (r_round == LAST_RND) begin
            // Final swap: output is FP(R16 || L16).
            r_text  <= fp_perm({w_r_nxt, r_r});
            r_round <= '0;
            r_state <= S_DONE;
          end else begin
            r_round <= r_round + 5'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic [0:7] r_par_err;

  // DES key bytes must have odd parity; flag the even ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_par_err <= '0;
    else if (w_accept)
      for (int i = 0; i < 8; i++) r_par_err[i] <= ~^key_din[8*i +: 8];
  end

  assign key_parity_err_dout = r_par_err;
`endif

  assign text_dout        = r_text;
  assign done_strobe_dout = (r_state == S_DONE);
  assign busy_dout        = (r_state != S_IDLE);

endmodule

// File: tb/tb_des_round_engine.sv
// Directed-vector bench for des_round_engine using published DES known-answer vectors.
module tb_des_round_engine;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        dec = 1'b0;
  logic [0:63] txt = '0;
  logic [0:63] key = '0;
  logic [0:63] tout;
  logic        done, busy;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic [0:7]  perr;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  des_round_engine dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start_strobe_din (start),
    .decrypt_din      (dec),
    .text_din         (txt),
    .key_din          (key),
    .text_dout        (tout),
    .done_strobe_dout (done),
    .busy_dout        (busy)
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    .key_parity_err_dout (perr)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Done must rise at the 16th edge after the accepting edge (17th cycle counting the start cycle).
  task automatic run_block(input string tag, input logic d, input logic [63:0] k,
                           input logic [63:0] t, input logic [63:0] exp,
                           input bit ign, input bit chk_txt);
    int lat, dones, w;
    logic [63:0] res;
    lat = 0; dones = 0; w = 0; res = '0;
    while (busy && w < 40) begin tick; w++; end
    chk({tag, "/idle"}, 64'(busy), 64'd0);
    dec = d; key = k; txt = t; start = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, "/busy"}, 64'(busy), 64'd1);
    for (int n = 1; n <= 24; n++) begin
      if (ign && (n == 3 || n == 9)) begin
        start = 1'b1; dec = ~d; key = ~k; txt = ~t;
      end else begin
        start = 1'b0;
      end
      tick;
      if (done) begin
        dones++;
        if (dones == 1) begin lat = n; res = tout; end
      end
    end
    start = 1'b0;
    chk({tag, "/latency"}, 64'(lat), 64'd16);
    chk({tag, "/dones"}, 64'(dones), 64'd1);
    if (chk_txt) chk({tag, "/text"}, res, exp);
  endtask

  initial begin
    int dones;
    repeat (3) tick;
    chk("rst/text", tout, 64'd0);
    chk("rst/done", 64'(done), 64'd0);
    chk("rst/busy", 64'(busy), 64'd0);
`ifdef DES_KEY_PARITY_CHECK_EN
    chk("rst/perr", 64'(perr), 64'd0);
`endif
    reset_n = 1'b1;
    tick;

    run_block("enc1", 1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 0, 1);
    run_block("dec1", 1'b1, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, 1);
    run_block("enc2", 1'b0, 64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0000000000000000, 0, 1);
    run_block("ignst", 1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 1, 1);
    run_block("after", 1'b1, 64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787, 0, 1);

    // Abort a block mid-flight with reset; nothing from it may surface.
    dec = 1'b0; key = 64'h133457799BBCDFF1; txt = 64'h0123456789ABCDEF; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (7) tick;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst/text", tout, 64'd0);
    chk("midrst/done", 64'(done), 64'd0);
    chk("midrst/busy", 64'(busy), 64'd0);
    tick; tick;
    reset_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 20; n++) begin
      tick;
      if (done) dones++;
    end
    chk("midrst/stray", 64'(dones), 64'd0);
    run_block("postrst", 1'b1, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, 1);

`ifdef DES_KEY_PARITY_CHECK_EN
    chk("par/good", 64'(perr), 64'd0);
    run_block("parz", 1'b0, 64'h0, 64'h0, 64'h0, 0, 0);
    chk("par/zero", 64'(perr), 64'hFF);
    run_block("parm", 1'b0, 64'h0100000000000001, 64'h0, 64'h0, 0, 0);
    chk("par/mix", 64'(perr), 64'h7E);
    run_block("park", 1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 0, 1);
    chk("par/ok", 64'(perr), 64'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
